// File: rtl/grf_2w_trace_if.sv
// Bus bundle for grf_2w_trace: read ports, dual write/retire ports and trace drain.
interface grf_2w_trace_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              regwrite;
  logic [31:0]       pc_new;
  logic [ADDR_W-1:0] A4;
  logic [DATA_W-1:0] WD4;
  logic              regwrite2;
  logic [31:0]       pc_new2;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_pc;
  logic [ADDR_W-1:0] trace_addr;
  logic [DATA_W-1:0] trace_data;
  logic              trace_overflow;

  modport master (
    output A1, A2, A3, WD3, regwrite, pc_new, A4, WD4, regwrite2, pc_new2, trace_ready,
    input  RD1, RD2, trace_valid, trace_pc, trace_addr, trace_data, trace_overflow
  );

  modport slave (
    input  A1, A2, A3, WD3, regwrite, pc_new, A4, WD4, regwrite2, pc_new2, trace_ready,
    output RD1, RD2, trace_valid, trace_pc, trace_addr, trace_data, trace_overflow
  );
endinterface

// File: rtl/grf_2w_trace.sv
// Two-read / two-write general register file with optional write-to-read bypass
// and a first-word-fall-through trace FIFO of committed register writes.
module grf_2w_trace #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int ZERO_REG    = 1,
  parameter int BYPASS      = 1,
  parameter int TRACE_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  grf_2w_trace_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int PW   = $clog2(TRACE_DEPTH);
  localparam int CW   = PW + 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  rec_t              fifo_q [TRACE_DEPTH];
  rec_t              fifo_d [TRACE_DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              eff0, eff1;
  logic              pop;
  logic [CW-1:0]     free;
  logic              acc0, acc1;

  // Read mux: stored value, overridden by same-cycle writes (younger port last), zero reg forced.
  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored,
    input logic              e0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              e1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYPASS != 0) begin
      if (e0 && (a0 == a)) v = d0;
      if (e1 && (a1 == a)) v = d1;
    end
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    return v;
  endfunction

  // Effective-write qualification shared by the array and the trace.
  always_comb begin
    eff0 = bus.regwrite  && ((ZERO_REG == 0) || (bus.A3 != '0));
    eff1 = bus.regwrite2 && ((ZERO_REG == 0) || (bus.A4 != '0));
  end

  // Array update: port 1 applied after port 0 so the younger write wins on a collision.
  always_comb begin
    regs_d = regs_q;
    if (eff0) regs_d[bus.A3] = bus.WD3;
    if (eff1) regs_d[bus.A4] = bus.WD4;
  end

  // Combinational read ports.
  always_comb begin
    bus.RD1 = rd_sel(bus.A1, regs_q[bus.A1], eff0, bus.A3, bus.WD3, eff1, bus.A4, bus.WD4);
    bus.RD2 = rd_sel(bus.A2, regs_q[bus.A2], eff0, bus.A3, bus.WD3, eff1, bus.A4, bus.WD4);
  end

  // Trace FIFO: a same-cycle pop frees a slot before pushes; port 0 record claims space first,
  // so when full-with-pop the write slot equals the head slot, which is read this cycle anyway.
  always_comb begin
    pop      = (count_q != '0) && bus.trace_ready;
    free     = CW'(TRACE_DEPTH) - count_q + CW'(pop);
    acc0     = eff0 && (free != '0);
    acc1     = eff1 && ((free - CW'(acc0)) != '0);
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    if (acc0) begin
      fifo_d[wr_ptr_d] = '{pc: bus.pc_new, addr: bus.A3, data: bus.WD3};
      wr_ptr_d         = wr_ptr_d + 1'b1;
    end
    if (acc1) begin
      fifo_d[wr_ptr_d] = '{pc: bus.pc_new2, addr: bus.A4, data: bus.WD4};
      wr_ptr_d         = wr_ptr_d + 1'b1;
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);
    ovf_d    = ovf_q | (eff0 && !acc0) | (eff1 && !acc1);
  end

  // Head presentation; outputs read zero while the FIFO is empty.
  always_comb begin
    bus.trace_valid    = (count_q != '0);
    bus.trace_overflow = ovf_q;
    bus.trace_pc       = '0;
    bus.trace_addr     = '0;
    bus.trace_data     = '0;
    if (count_q != '0) begin
      bus.trace_pc   = fifo_q[rd_ptr_q].pc;
      bus.trace_addr = fifo_q[rd_ptr_q].addr;
      bus.trace_data = fifo_q[rd_ptr_q].data;
    end
  end

  // State registers with synchronous reset; reset overrides any write or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q   <= '{default: '0};
      fifo_q   <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      fifo_q   <= fifo_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_grf_2w_trace.sv
// Randomised and directed bench for grf_2w_trace against a queue-based reference model.
module tb_grf_2w_trace;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_2w_trace_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  grf_2w_trace #(
    .DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0]   pc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } rec_t;

  logic [DW-1:0] m_regs [32];
  rec_t          m_q [$];
  bit            m_ovf;
  int            checks   = 0;
  int            failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_eff(input logic we, input logic [AW-1:0] a);
    return we && (a != '0);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    if (a == '0) return '0;
    v = m_regs[a];
    if (m_eff(bus.regwrite, bus.A3) && bus.A3 == a) v = bus.WD3;
    if (m_eff(bus.regwrite2, bus.A4) && bus.A4 == a) v = bus.WD4;
    return v;
  endfunction

  task automatic m_push(input logic [31:0] pc, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rec_t r;
    r.pc = pc; r.a = a; r.d = d;
    if (m_q.size() < DEPTH) m_q.push_back(r);
    else m_ovf = 1'b1;
    m_regs[a] = d;
  endtask

  // One clock: compare outputs mid-cycle, advance the model, then move just past the edge.
  task automatic step();
    rec_t h;
    @(negedge clk);
    if (!reset) begin
      check("rd1", bus.RD1, m_read(bus.A1));
      check("rd2", bus.RD2, m_read(bus.A2));
      check("tvalid", bus.trace_valid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        h = m_q[0];
        check("tpc", bus.trace_pc, h.pc);
        check("taddr", bus.trace_addr, h.a);
        check("tdata", bus.trace_data, h.d);
      end
      check("tovf", bus.trace_overflow, m_ovf);
    end
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (m_q.size() != 0 && bus.trace_ready) void'(m_q.pop_front());
      if (m_eff(bus.regwrite, bus.A3))  m_push(bus.pc_new,  bus.A3, bus.WD3);
      if (m_eff(bus.regwrite2, bus.A4)) m_push(bus.pc_new2, bus.A4, bus.WD4);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.regwrite  = 1'b0;
    bus.regwrite2 = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] pc);
    bus.regwrite = 1'b1; bus.A3 = a; bus.WD3 = d; bus.pc_new = pc;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] pc);
    bus.regwrite2 = 1'b1; bus.A4 = a; bus.WD4 = d; bus.pc_new2 = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ovf = 1'b0;
    bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.A4 = '0;
    bus.WD3 = '0; bus.WD4 = '0; bus.pc_new = '0; bus.pc_new2 = '0;
    bus.trace_ready = 1'b0;
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_valid", bus.trace_valid, 1'b0);
    check("rst_ovf", bus.trace_overflow, 1'b0);
    check("rst_pc", bus.trace_pc, 32'h0);
    check("rst_addr", bus.trace_addr, 5'd0);
    check("rst_data", bus.trace_data, 32'h0);

    // Single write then read back and trace head
    wr0(5'd5, 32'h1234, 32'h3000);
    bus.A1 = 5'd5;
    step();
    idle();
    check("w1_rd1", bus.RD1, 32'h1234);
    check("w1_tpc", bus.trace_pc, 32'h3000);
    check("w1_taddr", bus.trace_addr, 5'd5);
    check("w1_tdata", bus.trace_data, 32'h1234);
    step();
    bus.trace_ready = 1'b1;
    step();
    bus.trace_ready = 1'b0;

    // Same-address dual write: younger wins in array and bypass, both traced
    wr0(5'd7, 32'hAAAA, 32'h4000);
    wr1(5'd7, 32'hBBBB, 32'h4004);
    bus.A1 = 5'd7;
    #1;
    check("dual_bypass", bus.RD1, 32'hBBBB);
    step();
    idle();
    check("dual_stored", bus.RD1, 32'hBBBB);
    check("dual_head0", bus.trace_data, 32'hAAAA);
    bus.trace_ready = 1'b1;
    step();
    check("dual_head1", bus.trace_data, 32'hBBBB);
    step();
    bus.trace_ready = 1'b0;

    // Write to register 0 is discarded and untraced
    wr0(5'd0, 32'hFFFF, 32'h5000);
    bus.A1 = 5'd0;
    step();
    idle();
    check("zero_rd", bus.RD1, 32'h0);
    check("zero_notrace", bus.trace_valid, 1'b0);

    // Fill to capacity with no drain, then overflow, then drain in order
    for (int i = 0; i < 4; i++) begin
      wr0(AW'(2 * i + 1), $urandom, 32'h6000 + 32'(8 * i));
      wr1(AW'(2 * i + 2), $urandom, 32'h6004 + 32'(8 * i));
      step();
    end
    idle();
    check("full_noovf", bus.trace_overflow, 1'b0);
    wr0(5'd20, 32'hDEAD, 32'h7000);
    step();
    idle();
    check("full_ovf", bus.trace_overflow, 1'b1);
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("drained", bus.trace_valid, 1'b0);
    check("ovf_sticky", bus.trace_overflow, 1'b1);
    bus.trace_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Seven pending, dual write with a simultaneous pop: both accepted
    for (int i = 0; i < 3; i++) begin
      wr0(AW'(i + 1), $urandom, 32'h8000 + 32'(8 * i));
      wr1(AW'(i + 11), $urandom, 32'h8004 + 32'(8 * i));
      step();
    end
    idle();
    wr0(5'd25, $urandom, 32'h8100);
    step();
    idle();
    bus.trace_ready = 1'b1;
    wr0(5'd26, $urandom, 32'h8200);
    wr1(5'd27, $urandom, 32'h8204);
    step();
    idle();
    check("popfree_ovf", bus.trace_overflow, 1'b0);
    for (int i = 0; i < 8; i++) step();
    check("popfree_empty", bus.trace_valid, 1'b0);
    bus.trace_ready = 1'b0;

    // Reset with pending records and a write in the reset cycle
    for (int i = 0; i < 3; i++) begin
      wr0(AW'(i + 1), $urandom, 32'h9000 + 32'(4 * i));
      step();
    end
    wr0(5'd9, 32'hCAFE, 32'h9100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle();
    bus.A1 = 5'd9;
    bus.A2 = 5'd1;
    #1;
    check("rstmid_valid", bus.trace_valid, 1'b0);
    check("rstmid_rd9", bus.RD1, 32'h0);
    check("rstmid_rd1", bus.RD2, 32'h0);
    step();

    // Random traffic over a narrow address range to force collisions and zero-reg hits
    for (int n = 0; n < 400; n++) begin
      bus.A1          = AW'($urandom_range(0, 7));
      bus.A2          = AW'($urandom_range(0, 7));
      bus.regwrite    = ($urandom_range(0, 3) != 0);
      bus.A3          = AW'($urandom_range(0, 7));
      bus.WD3         = $urandom;
      bus.pc_new      = $urandom;
      bus.regwrite2   = ($urandom_range(0, 2) != 0);
      bus.A4          = AW'($urandom_range(0, 7));
      bus.WD4         = $urandom;
      bus.pc_new2     = $urandom;
      bus.trace_ready = ($urandom_range(0, 2) == 0);
      reset           = ($urandom_range(0, 59) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
